// File: rtl/ltm_scanout.sv
// Raster timing generator and pixel scanout for the LTM panel: free-running h/v counters,
// a SEEK/RUN alignment FSM against the upstream frame stream, and registered panel outputs.
module ltm_scanout #(
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int H_SYNC   = 30,
    parameter int H_BACK   = 186,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 13,
    parameter int V_BACK   = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sop,
    output logic        pix_ready,
    output logic [7:0]  ltm_r,
    output logic [7:0]  ltm_g,
    output logic [7:0]  ltm_b,
    output logic        ltm_den,
    output logic        ltm_hd,
    output logic        ltm_vd,
    output logic        frame_start,
    output logic [15:0] err_count
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic {SEEK, RUN} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          first_px;
    state_t        state;
    state_t        state_nxt;
    logic          show;
    logic          err;

    logic [23:0]   rgb_p1;
    logic          den_p1;
    logic          hd_p1;
    logic          vd_p1;
    logic          fs_p1;
    logic [15:0]   err_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign active   = (h >= H_ACT_START) && (h < H_ACT_END) &&
                      (v >= V_ACT_START) && (v < V_ACT_END);
    assign first_px = (h == H_ACT_START) && (v == V_ACT_START);

    // In RUN any active cycle where sop disagrees with the raster origin is a framing fault;
    // a sop waiting in the blanking interval is simply held until the origin comes round.
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        show      = 1'b0;
        err       = 1'b0;
        case (state)
            SEEK: begin
                pix_ready = !(pix_valid && pix_sop) || first_px;
                if (first_px && pix_valid && pix_sop) begin
                    show      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pix_ready = active && !(pix_valid && pix_sop && !first_px);
                if (active) begin
                    if (!pix_valid || (pix_sop != first_px)) begin
                        err       = 1'b1;
                        state_nxt = SEEK;
                    end else begin
                        show = 1'b1;
                    end
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    // Stage p1: every panel output registered together so sync, DEN and colour stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= SEEK;
            rgb_p1 <= '0;
            den_p1 <= 1'b0;
            hd_p1  <= 1'b1;
            vd_p1  <= 1'b1;
            fs_p1  <= 1'b0;
            err_p1 <= '0;
        end else begin
            state  <= state_nxt;
            rgb_p1 <= show ? pix_data : 24'h0;
            den_p1 <= active;
            hd_p1  <= (h >= H_SYNC_END);
            vd_p1  <= (v >= V_SYNC_END);
            fs_p1  <= (h == '0) && (v == '0);
            if (err) begin
                err_p1 <= sat_inc(err_p1);
            end
        end
    end

    assign ltm_r       = rgb_p1[23:16];
    assign ltm_g       = rgb_p1[15:8];
    assign ltm_b       = rgb_p1[7:0];
    assign ltm_den     = den_p1;
    assign ltm_hd      = hd_p1;
    assign ltm_vd      = vd_p1;
    assign frame_start = fs_p1;
    assign err_count   = err_p1;

endmodule

// File: tb/tb_ltm_scanout.sv
// Bench for ltm_scanout on a shrunken raster: a cycle-indexed raster model drives per-cycle
// checks of every output and pix_ready, plus hand-computed per-frame totals.
module tb_ltm_scanout;

    localparam int HA = 8, HF = 2, HS = 3, HB = 4;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 17
    localparam int VT = VA + VF + VS + VB;   // 11
    localparam int FT = HT * VT;             // 187

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_sop;
    logic        pix_ready;
    logic [7:0]  ltm_r, ltm_g, ltm_b;
    logic        ltm_den, ltm_hd, ltm_vd, frame_start;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    ltm_scanout #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_ready(pix_ready),
        .ltm_r(ltm_r), .ltm_g(ltm_g), .ltm_b(ltm_b),
        .ltm_den(ltm_den), .ltm_hd(ltm_hd), .ltm_vd(ltm_vd),
        .frame_start(frame_start), .err_count(err_count)
    );

    typedef struct packed {
        logic        sop;
        logic [23:0] data;
    } px_t;

    px_t         q[$];
    bit          drop_arm;
    logic [23:0] drop_data;

    int n_chk, n_pass;
    int m_t, m_err;
    bit m_locked, chk_on;
    logic [43:0] exp_cur;

    logic [23:0] s_rgb;
    logic        s_den, s_hd, s_vd, s_fs;
    logic [15:0] s_err;
    int          n_hd_low, n_vd_low, n_den, n_fs, n_rgb_nz, n_nonblack, n_acc;
    bit          got_first;
    logic [23:0] first_den, last_den;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    task automatic push_frame(input int f, input int n);
        for (int i = 0; i < n; i++) begin
            px_t p;
            p.sop  = (i == 0);
            p.data = {8'(f), 16'(i)};
            q.push_back(p);
        end
    endtask

    task automatic clr();
        n_hd_low = 0; n_vd_low = 0; n_den = 0; n_fs = 0;
        n_rgb_nz = 0; n_nonblack = 0; n_acc = 0; got_first = 0;
        first_den = '0; last_den = '0;
    endtask

    // Raster position comes straight from the cycle index since the last reset.
    task automatic model_eval();
        int ph, pv;
        bit act, first, show, rdy, fault;
        if (reset) begin
            m_t      = 0;
            m_locked = 0;
            m_err    = 0;
            exp_cur  = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
            chk_on   = 1;
            return;
        end
        ph    = m_t % HT;
        pv    = (m_t / HT) % VT;
        act   = (ph >= HS + HB) && (ph < HS + HB + HA) && (pv >= VS + VB) && (pv < VS + VB + VA);
        first = (ph == HS + HB) && (pv == VS + VB);
        show  = 0;
        if (!m_locked) begin
            rdy = !(pix_valid && pix_sop) || first;
            if (first && pix_valid && pix_sop) begin
                show     = 1;
                m_locked = 1;
            end
        end else begin
            rdy   = act && !(pix_valid && pix_sop && !first);
            fault = act && (!pix_valid || (pix_sop && !first) || (first && !pix_sop));
            if (fault) begin
                m_locked = 0;
                if (m_err < 65535) m_err++;
            end else begin
                show = act;
            end
        end
        if (chk_on) chk("ready", 48'(pix_ready), 48'(rdy));
        exp_cur = {show ? pix_data : 24'h0, act, ph >= HS, pv >= VS, (ph == 0) && (pv == 0), 16'(m_err)};
        m_t++;
    endtask

    task automatic step();
        bit fire;
        if (q.size() > 0) begin
            pix_valid = 1'b1;
            pix_sop   = q[0].sop;
            pix_data  = q[0].data;
            if (drop_arm && q[0].data == drop_data) begin
                pix_valid = 1'b0;
                drop_arm  = 0;
            end
        end else begin
            pix_valid = 1'b0;
            pix_sop   = 1'b0;
            pix_data  = '0;
        end
        @(negedge clk);
        s_rgb = {ltm_r, ltm_g, ltm_b};
        s_den = ltm_den; s_hd = ltm_hd; s_vd = ltm_vd; s_fs = frame_start; s_err = err_count;
        if (chk_on)
            chk("outputs", 48'({s_rgb, s_den, s_hd, s_vd, s_fs, s_err}), 48'(exp_cur));
        n_hd_low += (s_hd == 1'b0) ? 1 : 0;
        n_vd_low += (s_vd == 1'b0) ? 1 : 0;
        n_den    += s_den ? 1 : 0;
        n_fs     += s_fs ? 1 : 0;
        n_rgb_nz += (s_rgb != 0) ? 1 : 0;
        if (s_den) begin
            if (!got_first) first_den = s_rgb;
            got_first = 1;
            last_den  = s_rgb;
            if (s_rgb != 0) n_nonblack++;
        end
        fire = pix_valid && pix_ready;
        n_acc += fire ? 1 : 0;
        model_eval();
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
    endtask

    initial begin
        n_chk = 0; n_pass = 0; chk_on = 0; drop_arm = 0; drop_data = '0;
        reset = 1'b1; pix_valid = 1'b0; pix_sop = 1'b0; pix_data = '0;
        clr();

        repeat (5) step();
        chk("rst_hd", 48'(s_hd), 48'd1);
        chk("rst_vd", 48'(s_vd), 48'd1);
        chk("rst_den_rgb", 48'({s_den, s_rgb}), 48'd0);
        reset = 1'b0;
        step();
        chk("rel_hold", 48'({s_hd, s_vd, s_den, s_fs}), 48'b1100);
        clr();
        step();
        chk("origin", 48'({s_hd, s_vd, s_fs}), 48'b001);

        // Two idle frames.
        repeat (2 * FT - 1) step();
        chk("idle_hd_low", 48'(n_hd_low), 48'd66);
        chk("idle_vd_low", 48'(n_vd_low), 48'd68);
        chk("idle_den", 48'(n_den), 48'd96);
        chk("idle_fs", 48'(n_fs), 48'd2);
        chk("idle_rgb", 48'(n_rgb_nz), 48'd0);
        chk("idle_err", 48'(s_err), 48'd0);

        // Ideal source, three frames.
        push_frame(0, 48); push_frame(1, 48); push_frame(2, 48);
        for (int f = 0; f < 3; f++) begin
            clr();
            repeat (FT) step();
            chk("ideal_acc", 48'(n_acc), 48'd48);
            chk("ideal_den", 48'(n_den), 48'd48);
            chk("ideal_first", 48'(first_den), 48'({8'(f), 16'h0000}));
            chk("ideal_last", 48'(last_den), 48'({8'(f), 16'h002F}));
        end
        chk("ideal_err", 48'(s_err), 48'd0);

        // Valid dropped at pixel 20 of frame 3.
        push_frame(3, 48); push_frame(4, 48);
        drop_arm = 1; drop_data = 24'h030014;
        clr();
        repeat (FT) step();
        chk("drop_shown", 48'(n_nonblack), 48'd20);
        chk("drop_acc", 48'(n_acc), 48'd48);
        chk("drop_err", 48'(s_err), 48'd1);
        clr();
        repeat (FT) step();
        chk("drop_next_first", 48'(first_den), 48'h040000);
        chk("drop_next_shown", 48'(n_nonblack), 48'd48);
        chk("drop_next_err", 48'(s_err), 48'd1);

        // Early sop: frame 5 is cut short at pixel 10.
        push_frame(5, 10); push_frame(6, 48);
        clr();
        repeat (FT) step();
        chk("esop_shown", 48'(n_nonblack), 48'd10);
        chk("esop_acc", 48'(n_acc), 48'd10);
        chk("esop_err", 48'(s_err), 48'd2);
        clr();
        repeat (FT) step();
        chk("esop_next_first", 48'(first_den), 48'h060000);
        chk("esop_next_acc", 48'(n_acc), 48'd48);
        chk("esop_next_err", 48'(s_err), 48'd2);

        // Reset in the middle of frame 7, then frame 8.
        push_frame(7, 48);
        clr();
        repeat (6 * HT) step();
        chk("mid_acc", 48'(n_acc), 48'd16);
        push_frame(8, 48);
        reset = 1'b1;
        repeat (3) step();
        chk("mid_rst_out", 48'({s_hd, s_vd, s_den, s_err}), 48'({3'b110, 16'h0}));
        reset = 1'b0;
        step();
        clr();
        repeat (FT) step();
        chk("mid_first", 48'(first_den), 48'h080000);
        chk("mid_last", 48'(last_den), 48'h08002F);
        chk("mid_shown", 48'(n_nonblack), 48'd48);
        chk("mid_err", 48'(s_err), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
